// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO; all sizing is per instance.
package sync_fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? 32'($clog2(depth)) : 32'd1;
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return 32'($clog2(depth + 32'd1));
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Storage index counter that wraps from DEPTH-1 back to 0, so DEPTH need not be a power of two.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       inc_i,
  output logic [$clog2(DEPTH)-1:0]   ptr_o
);

  localparam int unsigned PW = ptr_width(DEPTH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= (ptr_o == PW'(DEPTH - 1)) ? '0 : ptr_o + PW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with fill level and almost flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         we_i,
  input  logic                         re_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         overflow_o,
  output logic                         underflow_o,
  input  logic                         err_clr_i
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [LW-1:0]    level_q;
  logic             push_acc;
  logic             pop_acc;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_acc  = re_i & ~empty_o;
  assign push_acc = we_i & (~full_o | pop_acc);

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (push_acc),
    .ptr_o (wptr)
  );

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (pop_acc),
    .ptr_o (rptr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_acc) begin
      mem[wptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
    end else if (push_acc && !pop_acc) begin
      level_q <= level_q + LW'(1);
    end else if (pop_acc && !push_acc) begin
      level_q <= level_q - LW'(1);
    end
  end

  // Flags decode straight from the level register so they track level_o exactly.
  assign rdata_o        = mem[rptr];
  assign level_o        = level_q;
  assign empty_o        = (level_q == '0);
  assign full_o         = (level_q == LW'(DEPTH));
  assign almost_full_o  = (32'(level_q) >= AFULL_THRESH);
  assign almost_empty_o = (32'(level_q) <= AEMPTY_THRESH);

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (we_i && full_o && !pop_acc) begin
        overflow_o <= 1'b1;
      end else if (err_clr_i) begin
        overflow_o <= 1'b0;
      end
      if (re_i && empty_o) begin
        underflow_o <= 1'b1;
      end else if (err_clr_i) begin
        underflow_o <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a DEPTH=16 instance and a non-power-of-2 DEPTH=5 instance.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, re, clr;
  logic [31:0] wd, rdata;
  logic        full, empty, af, ae, ovf, unf;
  logic [4:0]  lvl;

  logic        rst5, we5, re5, clr5;
  logic [7:0]  wd5, rdata5;
  logic        full5, empty5, af5, ae5, ovf5, unf5;
  logic [2:0]  lvl5;

  sync_fifo #(.WIDTH(32), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u16 (
    .clk_i(clk), .rst_i(rst), .wdata_i(wd), .we_i(we), .re_i(re), .rdata_o(rdata),
    .full_o(full), .empty_o(empty), .almost_full_o(af), .almost_empty_o(ae),
    .level_o(lvl), .overflow_o(ovf), .underflow_o(unf), .err_clr_i(clr)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(5)) u5 (
    .clk_i(clk), .rst_i(rst5), .wdata_i(wd5), .we_i(we5), .re_i(re5), .rdata_o(rdata5),
    .full_o(full5), .empty_o(empty5), .almost_full_o(af5), .almost_empty_o(ae5),
    .level_o(lvl5), .overflow_o(ovf5), .underflow_o(unf5), .err_clr_i(clr5)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic r, input logic w, input logic p, input logic c,
                         input logic [31:0] d);
    rst = r; we = w; re = p; clr = c; wd = d;
  endtask

  task automatic flags16(input string tag, input int l);
    chk({tag, ".level"}, 32'(lvl), 32'(l));
    chk({tag, ".full"},  32'(full),  32'(l == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(l == 0));
    chk({tag, ".afull"}, 32'(af),    32'(l >= 14));
    chk({tag, ".aempty"},32'(ae),    32'(l <= 2));
  endtask

  typedef struct {
    logic        rst, we, re, clr;
    logic [31:0] wd;
    int          lvl;
    logic        chk_rd;
    logic [31:0] rd;
    logic        unf;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] q5[$];
  bit we_p[24];
  bit re_p[24];

  initial begin
    drive16(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rst5 = 1'b1; we5 = 1'b0; re5 = 1'b0; clr5 = 1'b0; wd5 = 8'h0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hAB, 1, 1'b1, 32'hAB, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1, 32'hAB, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hCD, 2, 1'b1, 32'hAB, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hEF, 3, 1'b1, 32'hAB, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 2, 1'b1, 32'hCD, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1, 1'b1, 32'hEF, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11, 1, 1'b1, 32'h11, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 0, 1'b0, 32'h00, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 0, 1'b0, 32'h00, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b0, 32'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h22, 0, 1'b0, 32'h00, 1'b0};

    // Reset, empty push+pop, sticky clear, set-vs-clear, reset priority.
    for (int i = 0; i < 12; i++) begin
      drive16(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].wd);
      tick();
      flags16($sformatf("vec%0d", i), tbl[i].lvl);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d.rdata", i), rdata, tbl[i].rd);
      chk($sformatf("vec%0d.underflow", i), 32'(unf), 32'(tbl[i].unf & ERR_EN));
      chk($sformatf("vec%0d.overflow", i), 32'(ovf), 32'h0);
    end

    // Fill to full with threshold crossings, then push into a full FIFO.
    for (int i = 0; i < 16; i++) begin
      drive16(1'b0, 1'b1, 1'b0, 1'b0, 32'(i));
      tick();
      flags16($sformatf("fill%0d", i), i + 1);
      chk("fill.head", rdata, 32'h0);
    end
    drive16(1'b0, 1'b1, 1'b0, 1'b0, 32'd99);
    tick();
    flags16("ovf_push", 16);
    chk("ovf_push.overflow", 32'(ovf), 32'(ERR_EN));
    chk("ovf_push.head", rdata, 32'h0);
    drive16(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("ovf_clr.overflow", 32'(ovf), 32'h0);

    // Push and pop together while full.
    drive16(1'b0, 1'b1, 1'b1, 1'b0, 32'd100);
    tick();
    flags16("full_both", 16);
    chk("full_both.head", rdata, 32'd1);
    chk("full_both.overflow", 32'(ovf), 32'h0);

    // Drain and check order, including the word pushed while full.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.head", i), rdata, (i < 15) ? 32'(i + 1) : 32'd100);
      drive16(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      flags16($sformatf("drain%0d", i), 15 - i);
    end
    chk("drain.underflow", 32'(unf), 32'h0);

    // Underflow, refill to 7, then reset mid-operation.
    drive16(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("empty_pop.underflow", 32'(unf), 32'(ERR_EN));
    for (int i = 0; i < 7; i++) begin
      drive16(1'b0, 1'b1, 1'b0, 1'b0, 32'(i + 200));
      tick();
    end
    flags16("lvl7", 7);
    chk("lvl7.head", rdata, 32'd200);
    drive16(1'b1, 1'b1, 1'b1, 1'b0, 32'h55);
    tick();
    flags16("rst7", 0);
    chk("rst7.underflow", 32'(unf), 32'h0);
    chk("rst7.overflow", 32'(ovf), 32'h0);
    drive16(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // DEPTH=5: mixed-rate traffic across pointer wrap against a queue model.
    rst5 = 1'b1;
    tick();
    rst5 = 1'b0;
    chk("d5_rst.level", 32'(lvl5), 32'h0);
    chk("d5_rst.empty", 32'(empty5), 32'h1);
    for (int k = 0; k < 24; k++) begin
      we_p[k] = (k < 10) || (k >= 14 && k < 18) || (k == 19);
      re_p[k] = (k >= 6 && k < 14) || (k >= 18);
    end
    for (int k = 0; k < 24; k++) begin
      bit pop_ok, push_ok;
      we5 = we_p[k]; re5 = re_p[k]; wd5 = 8'(k + 1);
      pop_ok  = re5 && (q5.size() > 0);
      push_ok = we5 && ((q5.size() < 5) || pop_ok);
      tick();
      if (pop_ok)  void'(q5.pop_front());
      if (push_ok) q5.push_back(wd5);
      chk($sformatf("d5_c%0d.level", k), 32'(lvl5), 32'(q5.size()));
      chk($sformatf("d5_c%0d.full", k),  32'(full5),  32'(q5.size() == 5));
      chk($sformatf("d5_c%0d.empty", k), 32'(empty5), 32'(q5.size() == 0));
      chk($sformatf("d5_c%0d.afull", k), 32'(af5),    32'(q5.size() >= 3));
      chk($sformatf("d5_c%0d.aempty", k),32'(ae5),    32'(q5.size() <= 2));
      if (q5.size() > 0) chk($sformatf("d5_c%0d.head", k), 32'(rdata5), 32'(q5[0]));
    end
    we5 = 1'b0; re5 = 1'b0;
    chk("d5.overflow", 32'(ovf5), 32'(ERR_EN));
    chk("d5.underflow", 32'(unf5), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
